// File: rtl/imem_loader_if.sv
// Fetch and byte-loader signal bundle for imem_loader.
// The master side is the core/loader; the slave side is the memory.
interface imem_loader_if #(
  parameter int unsigned DEPTH_LOG2 = 8
);
  logic [31:0]         a;
  logic                re;
  logic [31:0]         rd;
  logic                rvalid;
  logic                err;
  logic                ld_start;
  logic [DEPTH_LOG2:0] ld_len;
  logic                ld_valid;
  logic [7:0]          ld_byte;
  logic                ld_ready;
  logic                ld_busy;
  logic                ld_done;

  modport master (
    output a, re, ld_start, ld_len, ld_valid, ld_byte,
    input  rd, rvalid, err, ld_ready, ld_busy, ld_done
  );

  modport slave (
    input  a, re, ld_start, ld_len, ld_valid, ld_byte,
    output rd, rvalid, err, ld_ready, ld_busy, ld_done
  );
endinterface

// File: rtl/imem_loader.sv
// Run-time loadable instruction memory: a byte-serial loader fills a word RAM
// with little-endian program bytes, then the core fetches with one-cycle latency.
module imem_loader #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] FILL_INST  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   hwm;
  logic [CW-1:0]   target;
  logic [1:0]      bcnt;
  logic [23:0]     part;

  logic                  accept_c;
  logic                  wr_en_c;
  logic                  last_c;
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                  bad_c;
  logic                  hit_c;
  logic [CW-1:0]         ld_target_c;

  // Handshake, word-complete and fetch-address decode
  always_comb begin
    accept_c    = (state == LOAD) && bus.ld_ready && bus.ld_valid && !bus.ld_start;
    wr_en_c     = accept_c && (bcnt == 2'd3);
    last_c      = wr_en_c && ((ptr + CW'(1)) == target);
    idx_c       = bus.a[DEPTH_LOG2+1:2];
    bad_c       = (bus.a[1:0] != 2'b00) || (bus.a[31:DEPTH_LOG2+2] != '0);
    hit_c       = ({1'b0, idx_c} < hwm);
    ld_target_c = (bus.ld_len > CW'(DEPTH)) ? CW'(DEPTH) : bus.ld_len;
  end

  // Word RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[ptr[DEPTH_LOG2-1:0]] <= {bus.ld_byte, part};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      hwm          <= '0;
      target       <= '0;
      bcnt         <= '0;
      part         <= '0;
      bus.rd       <= '0;
      bus.rvalid   <= 1'b0;
      bus.err      <= 1'b0;
      bus.ld_ready <= 1'b0;
      bus.ld_busy  <= 1'b0;
      bus.ld_done  <= 1'b0;
    end else begin
      bus.ld_done <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.err     <= 1'b0;
      // A load request wins over everything, including a pending fetch
      if (bus.ld_start) begin
        state        <= LOAD;
        ptr          <= '0;
        hwm          <= '0;
        bcnt         <= '0;
        part         <= '0;
        target       <= ld_target_c;
        bus.ld_busy  <= 1'b1;
        bus.ld_ready <= (ld_target_c != '0);
      end else begin
        unique case (state)
          IDLE: begin
            state <= IDLE;
          end
          LOAD: begin
            if (target == '0) begin
              state        <= RUN;
              bus.ld_busy  <= 1'b0;
              bus.ld_ready <= 1'b0;
              bus.ld_done  <= 1'b1;
            end else if (accept_c) begin
              bcnt <= bcnt + 2'd1;
              // Shift in from the top so byte 0 ends at bits 7:0
              part <= {bus.ld_byte, part[23:8]};
              if (wr_en_c) begin
                ptr <= ptr + CW'(1);
                hwm <= ptr + CW'(1);
              end
              if (last_c) begin
                state        <= RUN;
                bus.ld_busy  <= 1'b0;
                bus.ld_ready <= 1'b0;
                bus.ld_done  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.re) begin
              bus.rvalid <= 1'b1;
              bus.err    <= bad_c;
              bus.rd     <= bad_c ? 32'h0 : (hit_c ? mem[idx_c] : FILL_INST);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads programs byte-serially and checks
// fetches against a scoreboard of expected words.
module tb_imem_loader;
  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 1 << DL2;
  localparam int unsigned LW    = DL2 + 1;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.DEPTH_LOG2(DL2)) bus ();
  imem_loader #(.DEPTH_LOG2(DL2), .FILL_INST(FILL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  logic [31:0] mdl [DEPTH];
  int          mhwm = 0;
  int          mbcnt = 0;
  logic [31:0] mpart = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] addr);
    exp_t e;
    if (addr[1:0] != 2'b00 || addr[31:DL2+2] != '0) e = '{err: 1'b1, rd: 32'h0};
    else if (int'(addr[DL2+1:2]) >= mhwm)          e = '{err: 1'b0, rd: FILL};
    else                                            e = '{err: 1'b0, rd: mdl[addr[DL2+1:2]]};
    return e;
  endfunction

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'h1);
      chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
      chk({tag, "_rd"}, bus.rd, e.rd);
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input string tag);
    bus.a  = addr;
    bus.re = 1'b1;
    sb.push_back(model_fetch(addr));
    tick();
    bus.re = 1'b0;
    pop_chk(tag);
  endtask

  task automatic start_load(input int len);
    bus.ld_start = 1'b1;
    bus.ld_len   = LW'(len);
    tick();
    bus.ld_start = 1'b0;
    mhwm  = 0;
    mbcnt = 0;
    mpart = '0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$], input bit rnd, input bit expect_done, input string tag);
    int   idx = 0;
    int   guard = 0;
    int   dones = 0;
    logic rdy;
    while (idx < q.size() && guard < 500) begin
      bus.ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.ld_byte  = q[idx];
      rdy = bus.ld_ready;
      tick();
      guard++;
      if (bus.ld_done) dones++;
      if (bus.ld_valid && rdy) begin
        mpart[8*mbcnt +: 8] = q[idx];
        mbcnt++;
        if (mbcnt == 4) begin
          mdl[mhwm] = mpart;
          mhwm++;
          mbcnt = 0;
        end
        idx++;
      end
    end
    bus.ld_valid = 1'b0;
    if (guard >= 500) chk({tag, "_timeout"}, 32'(idx), 32'(q.size()));
    if (expect_done) begin
      chk({tag, "_ready_low"}, 32'(bus.ld_ready), 32'h0);
      chk({tag, "_done_pulse"}, 32'(bus.ld_done), 32'h1);
      tick();
      chk({tag, "_done_clear"}, 32'(bus.ld_done), 32'h0);
      chk({tag, "_busy_clear"}, 32'(bus.ld_busy), 32'h0);
      chk({tag, "_done_count"}, 32'(dones), 32'h1);
    end
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [31:0] s1 [3];
    int          wait_n;
    s1[0] = 32'h00100f93;
    s1[1] = 32'h0000408b;
    s1[2] = 32'h01ffcfb3;
    bus.a = '0; bus.re = 1'b0; bus.ld_start = 1'b0; bus.ld_len = '0;
    bus.ld_valid = 1'b0; bus.ld_byte = '0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;

    tick();
    tick();
    chk("rst_rd", bus.rd, 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_ready", 32'(bus.ld_ready), 32'h0);
    chk("rst_busy", 32'(bus.ld_busy), 32'h0);
    chk("rst_done", 32'(bus.ld_done), 32'h0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: three-word program, back-to-back bytes and fetches
    start_load(3);
    chk("s1_busy", 32'(bus.ld_busy), 32'h1);
    chk("s1_ready", 32'(bus.ld_ready), 32'h1);
    q = '{8'h93, 8'h0f, 8'h10, 8'h00, 8'h8b, 8'h40, 8'h00, 8'h00, 8'hb3, 8'hcf, 8'hff, 8'h01};
    send_bytes(q, 1'b0, 1'b1, "s1");
    for (int i = 0; i < 3; i++) begin
      bus.a  = 32'(4 * i);
      bus.re = 1'b1;
      sb.push_back('{err: 1'b0, rd: s1[i]});
      tick();
      pop_chk("s1_fetch");
    end
    bus.re = 1'b0;

    // Scenario 2: unloaded, misaligned and out-of-range fetches
    fetch(32'h0000_000C, "s2_fill");
    chk("s2_fill_const", bus.rd, FILL);
    fetch(32'h0000_0002, "s2_misalign");
    fetch(32'(4 * DEPTH), "s2_range");
    tick();
    chk("s2_idle_rvalid", 32'(bus.rvalid), 32'h0);
    chk("s2_idle_rd_hold", bus.rd, 32'h0);

    // Scenario 3: two-word load with gapped LD_VALID
    start_load(2);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    send_bytes(q, 1'b1, 1'b1, "s3");
    fetch(32'h0, "s3_w0");
    fetch(32'h4, "s3_w1");
    fetch(32'h8, "s3_w2_fill");

    // Scenario 4: restart after five bytes, then a one-word load
    start_load(4);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_bytes(q, 1'b0, 1'b0, "s4a");
    chk("s4_busy_mid", 32'(bus.ld_busy), 32'h1);
    start_load(1);
    q = '{8'h13, 8'h0b, 8'h40, 8'h04};
    send_bytes(q, 1'b0, 1'b1, "s4b");
    sb.push_back('{err: 1'b0, rd: 32'h04400b13});
    bus.a = 32'h0; bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    pop_chk("s4_w0");
    fetch(32'h4, "s4_w1_fill");
    chk("s4_w1_const", bus.rd, FILL);

    // Scenario 5: reset mid-load, idle fetch, zero-length load
    start_load(2);
    q = '{8'haa, 8'hbb, 8'hcc};
    send_bytes(q, 1'b0, 1'b0, "s5a");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s5_rd", bus.rd, 32'h0);
    chk("s5_rvalid", 32'(bus.rvalid), 32'h0);
    chk("s5_err", 32'(bus.err), 32'h0);
    chk("s5_ready", 32'(bus.ld_ready), 32'h0);
    chk("s5_busy", 32'(bus.ld_busy), 32'h0);
    chk("s5_done", 32'(bus.ld_done), 32'h0);
    bus.a = 32'h0; bus.re = 1'b1;
    tick();
    bus.re = 1'b0;
    chk("s5_idle_rvalid", 32'(bus.rvalid), 32'h0);
    start_load(0);
    chk("s5_len0_ready", 32'(bus.ld_ready), 32'h0);
    wait_n = 0;
    while (!bus.ld_done && wait_n < 3) begin
      tick();
      wait_n++;
    end
    chk("s5_len0_done", 32'(bus.ld_done), 32'h1);
    tick();
    fetch(32'h0, "s5_len0_fill");
    chk("s5_len0_const", bus.rd, FILL);

    // Scenario 6: load request and fetch in the same RUN cycle
    bus.ld_start = 1'b1; bus.ld_len = LW'(1);
    bus.a = 32'h0; bus.re = 1'b1;
    tick();
    bus.ld_start = 1'b0; bus.re = 1'b0;
    chk("s6_rvalid", 32'(bus.rvalid), 32'h0);
    chk("s6_busy", 32'(bus.ld_busy), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised, run-time loadable instruction memory for the RV32 core; replaces the hard-wired instruction ROM.
- A byte-serial loader fills a synchronous word RAM with little-endian program bytes after reset.
- The core then fetches 32-bit instructions with one-cycle latency.
- Adds explicit read-valid, a loaded-region tracker and an error flag for misaligned or out-of-range fetches.

Parameters:
- DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
- FILL_INST, 32'h00000000, value returned for in-range words not written since the last load started.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST_N  in  1  synchronous active-low reset.
- A  in  32  fetch byte address.
- RE  in  1  fetch request.
- RD  out  32  fetched instruction; registered.
- RVALID  out  1  RD valid for the request issued last cycle.
- ERR  out  1  fetch misaligned or out of range; same timing as RVALID.
- LD_START  in  1  begin a load; 1-cycle pulse.
- LD_LEN  in  DEPTH_LOG2+1  number of words to load; sampled with LD_START.
- LD_VALID  in  1  LD_BYTE valid.
- LD_BYTE  in  8  program byte.
- LD_READY  out  1  loader accepts a byte this cycle.
- LD_BUSY  out  1  load in progress.
- LD_DONE  out  1  1-cycle pulse when the load completes.

Behaviour:
- Reset (RST_N=0 at posedge):
  - State goes to IDLE.
  - RD=0; RVALID, ERR, LD_READY, LD_BUSY, LD_DONE = 0.
  - Word pointer, byte counter and loaded count HWM = 0.
  - RAM contents are not cleared.
  - Reset mid-load abandons the load; HWM=0.
- States:
  - IDLE: LD_START moves to LOAD; fetches are ignored.
  - LOAD:
    - LD_READY=1 and LD_BUSY=1.
    - A byte is accepted on LD_VALID && LD_READY.
    - Byte k of a word (k=0..3) goes to bits 8k+7:8k.
    - When the 4th byte is accepted, the word is written at the pointer, the pointer increments and HWM becomes pointer+1 in the same cycle.
    - When words written == target, the block moves to RUN and LD_DONE pulses in the cycle LD_READY drops.
    - Target = min(LD_LEN, DEPTH).
    - LD_LEN=0: go to RUN the next cycle, LD_DONE pulses, HWM=0.
    - Bytes beyond the target are not accepted (LD_READY=0).
  - RUN: fetches are served; LD_START re-enters LOAD.
- LD_START in LOAD restarts the load: pointer, byte counter and HWM go to 0, LD_LEN is resampled, and any partially assembled word is discarded.
- Fetch (RUN only):
  - RE=1 at cycle n gives RD/RVALID/ERR at n+1.
  - Word index is A[DEPTH_LOG2+1:2].
  - If A[1:0]!=0 or A[31:DEPTH_LOG2+2]!=0: RD=0, ERR=1.
  - Otherwise, if index >= HWM: RD=FILL_INST, ERR=0.
  - Otherwise: RD=RAM word, ERR=0.
- Fetch with RE=0, or in IDLE/LOAD: RVALID=0 and ERR=0 next cycle; RD holds its previous value.
- LD_START and RE in the same RUN cycle: LD_START wins, the fetch is dropped and RVALID=0 next cycle.
- Back-to-back fetches sustain one per cycle. A fetch to a word written in the same cycle cannot occur, since writes happen only in LOAD.
- RAM inference: a single synchronous write/read port (DEPTH x 32), no reset on the array.

Test Plan:
1. Reset then LD_START, LD_LEN=3, bytes 93 0f 10 00 8b 40 00 00 b3 cf ff 01 streamed back-to-back.
   - LD_DONE pulses once after the 12th byte.
   - Fetches at A=0,4,8 return 32'h00100f93, 32'h0000408b, 32'h01ffcfb3 one cycle later with RVALID=1, ERR=0.
2. After scenario 1, fetch A=0x0C.
   - RD=FILL_INST, ERR=0.
   - Fetch A=0x02 gives RD=0, ERR=1.
   - Fetch A=4*DEPTH gives RD=0, ERR=1.
3. LD_VALID toggling randomly during a 2-word load.
   - Only handshaken bytes are assembled.
   - Data matches the stream, and LD_READY=0 after the 8th byte.
4. LD_START again after 5 bytes of a 4-word load, then a new LD_LEN=1 load of 32'h04400b13.
   - A=0 returns 32'h04400b13.
   - A=4 returns FILL_INST (HWM=1).
5. RST_N=0 for one cycle mid-load.
   - All outputs reach reset values.
   - RE in IDLE gives RVALID=0.
   - LD_LEN=0 load gives LD_DONE next cycle, and a fetch at A=0 returns FILL_INST.
6. LD_START and RE asserted in the same RUN cycle.
   - RVALID=0 next cycle, LD_BUSY=1.
